// File: rtl/m_store_buf.sv
// Store buffer between the M stage and data memory.
// Stores are queued in strict FIFO order and drained one word at a time to memory.
// Loads that overlap a pending store word are held off until that store has drained.
module m_store_buf #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [31:0]              m_data_addr,
    input  logic [31:0]              m_data_wdata,
    input  logic [3:0]               m_data_byteen,
    input  logic                     m_load,
    output logic                     stall,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    output logic [31:0]              mem_wdata,
    output logic [3:0]               mem_byteen,
    input  logic                     mem_ack,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    // Entry storage. Only the word address is kept, because memory is written one word at a time.
    logic [29:0]   entAddr_q  [DEPTH];
    logic [31:0]   entData_q  [DEPTH];
    logic [3:0]    entByteen_q[DEPTH];

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [AW:0]   count_q, count_d;

    logic          pushAttempt;
    logic          loadCheck;
    logic          full;
    logic          pushOk;
    logic          pop;
    logic          loadHit;
    logic [AW-1:0] slotOffset;

    assign pushAttempt = |m_data_byteen;
    assign loadCheck   = m_load && !pushAttempt;
    assign full        = (count_q == (AW+1)'(DEPTH));
    assign pushOk      = pushAttempt && !full;
    assign pop         = (count_q != '0) && mem_ack;

    // Compare the load word address against every live entry, including a head being acked now.
    always_comb begin
        loadHit    = 1'b0;
        slotOffset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slotOffset = AW'(i) - head_q;
            if (({1'b0, slotOffset} < count_q) && (entAddr_q[i] == m_data_addr[31:2])) begin
                loadHit = 1'b1;
            end
        end
    end

    assign stall = (pushAttempt && full) || (loadCheck && loadHit);

    // Next-state pointers and occupancy; push and pop in the same cycle leave count unchanged.
    always_comb begin
        head_d  = head_q + AW'(pop);
        tail_d  = tail_q + AW'(pushOk);
        count_d = count_q + {{AW{1'b0}}, pushOk} - {{AW{1'b0}}, pop};
    end

    // Pointer and count registers, cleared immediately on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry payloads are written at the tail; the live range is tracked by head and count alone.
    always_ff @(posedge clk) begin
        if (reset && pushOk) begin
            entAddr_q[tail_q]   <= m_data_addr[31:2];
            entData_q[tail_q]   <= m_data_wdata;
            entByteen_q[tail_q] <= m_data_byteen;
        end
    end

    assign count      = count_q;
    assign empty      = (count_q == '0);
    assign mem_req    = !empty;
    assign mem_addr   = empty ? 32'h0 : {entAddr_q[head_q], 2'b00};
    assign mem_wdata  = empty ? 32'h0 : entData_q[head_q];
    assign mem_byteen = empty ? 4'h0  : entByteen_q[head_q];

endmodule
